// File: rtl/reverb_block_sequencer.sv
// rtl/reverb_block_sequencer.sv - toggle-request sequencer for the reverb block datapath
// Turns each req_in edge into a start pulse, tracks done/timeout, Avalon-MM status and irq.
module reverb_block_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_in,
  output logic        start,
  input  logic        done,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic             req_q;
  logic             armed;
  logic             pend;
  logic             overrun;
  logic             timeout;
  logic             irq_pend;
  logic             irq_en;
  logic [31:0]      busy_cnt;
  logic [31:0]      last_busy;
  logic [CNT_W-1:0] count;

  logic        req_edge;
  logic        wr_en;
  logic        clr_irq;
  logic        clr_ovr;
  logic        clr_tmo;
  logic [31:0] busy_next;
  logic        tmo_hit;
  logic        go_start;
  logic        unused_wdata;

  // armed masks the first clock so a request level already high at reset release is not a toggle
  assign req_edge  = armed & (req_in ^ req_q);
  assign wr_en     = chipselect & ~write_n;
  assign clr_irq   = wr_en & (address == 2'd0) & writedata[1];
  assign clr_ovr   = wr_en & (address == 2'd0) & writedata[3];
  assign clr_tmo   = wr_en & (address == 2'd0) & writedata[4];
  assign busy_next = (busy_cnt == 32'hFFFF_FFFF) ? busy_cnt : busy_cnt + 32'd1;
  assign tmo_hit   = (state == S_BUSY) & ~done & (busy_next >= TIMEOUT_CYCLES);
  assign go_start  = ((state == S_IDLE) & (req_edge | pend)) | ((state == S_DONE) & pend);
  assign irq       = irq_pend & irq_en;
  assign unused_wdata = ^{writedata[31:5], writedata[2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      start     <= 1'b0;
      req_q     <= 1'b0;
      armed     <= 1'b0;
      pend      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      irq_pend  <= 1'b0;
      irq_en    <= 1'b0;
      busy_cnt  <= 32'd0;
      last_busy <= 32'd0;
      count     <= '0;
    end else begin
      req_q <= req_in;
      armed <= 1'b1;
      start <= 1'b0;

      // a second request while one is already queued is dropped and flagged
      if (go_start)
        pend <= 1'b0;
      else if (req_edge & ~pend)
        pend <= 1'b1;

      if (req_edge & pend)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      if (tmo_hit)
        timeout <= 1'b1;
      else if (clr_tmo)
        timeout <= 1'b0;

      if (state == S_DONE)
        irq_pend <= 1'b1;
      else if (clr_irq)
        irq_pend <= 1'b0;

      if (wr_en & (address == 2'd3))
        irq_en <= writedata[0];

      case (state)
        S_IDLE: begin
          if (go_start) begin
            state <= S_START;
            start <= 1'b1;
          end
        end
        S_START: begin
          busy_cnt <= 32'd0;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          busy_cnt <= busy_next;
          if (done | tmo_hit)
            state <= S_DONE;
        end
        default: begin
          count     <= count + CNT_W'(1);
          last_busy <= busy_cnt;
          if (pend) begin
            state <= S_START;
            start <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {27'd0, timeout, overrun, pend, irq_pend, state != S_IDLE};
      2'd1:    readdata = 32'(count);
      2'd2:    readdata = last_busy;
      default: readdata = {31'd0, irq_en};
    endcase
  end

endmodule

// File: tb/tb_reverb_block_sequencer.sv
// tb/tb_reverb_block_sequencer.sv - scoreboard bench for reverb_block_sequencer
module tb_reverb_block_sequencer;

  localparam int TMO = 8;
  localparam int CW  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_in;
  logic        start;
  logic        done;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  reverb_block_sequencer #(.TIMEOUT_CYCLES(32'(TMO)), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req_in(req_in), .start(start), .done(done),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_op[$];
  int          q_addr[$];
  int unsigned q_val[$];
  string       q_name[$];
  int          exp_start[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_busy = 1'b0;

  int m_count, m_last, m_irq_pend, m_timeout, m_overrun, m_irq_en;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // monitor: sole owner of the bus and of all comparisons
  initial begin
    int op, a, e;
    int unsigned v;
    string nm;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        if (exp_start.size() == 0) check("start_unexpected", 1, 0);
        else begin
          e = exp_start.pop_front();
          check("start_cycle", cyc, e);
        end
      end
      if (q_op.size() > 0) begin
        mon_busy = 1'b1;
        op = q_op.pop_front(); a = q_addr.pop_front();
        v = q_val.pop_front(); nm = q_name.pop_front();
        case (op)
          0: begin
            address = a[1:0]; write_n = 1'b1; chipselect = 1'b1;
            #1 check(nm, readdata, v);
            chipselect = 1'b0;
          end
          1: begin
            address = a[1:0]; writedata = v; write_n = 1'b0; chipselect = 1'b1;
            @(posedge clk);
            #1 chipselect = 1'b0; write_n = 1'b1;
          end
          2: check(nm, irq, v);
          default: check(nm, exp_start.size(), 0);
        endcase
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_op(input int op, input int a, input int unsigned v, input string nm);
    q_op.push_back(op); q_addr.push_back(a); q_val.push_back(v); q_name.push_back(nm);
  endtask

  task automatic rd(input int a, input int unsigned v, input string nm);
    push_op(0, a, v, nm);
  endtask

  task automatic wr(input int a, input int unsigned v);
    push_op(1, a, v, "write");
  endtask

  task automatic chk_irq(input int v, input string nm);
    push_op(2, 0, v, nm);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (q_op.size() == 0 && !mon_busy) return;
      @(negedge clk);
      #2;
    end
    $display("FAIL bus_idle: monitor still busy after 64 cycles");
    $fatal(1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic toggle(output int s);
    req_in = ~req_in;
    s = cyc + 1;
    exp_start.push_back(s);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // reference: one finished block with d cycles of work, capped by the timeout
  task automatic model_block(input int d);
    m_count    = (m_count + 1) % (1 << CW);
    m_last     = (d > TMO) ? TMO : d;
    m_irq_pend = 1;
    if (d > TMO) m_timeout = 1;
  endtask

  function automatic int exp_status();
    return (m_timeout << 4) | (m_overrun << 3) | (m_irq_pend << 1);
  endfunction

  task automatic model_reset();
    m_count = 0; m_last = 0; m_irq_pend = 0; m_timeout = 0; m_overrun = 0; m_irq_en = 0;
  endtask

  task automatic check_model(input string p);
    rd(1, m_count, {p, "_count"});
    rd(2, m_last, {p, "_last_busy"});
    rd(0, exp_status(), {p, "_status"});
    chk_irq(m_irq_pend & m_irq_en, {p, "_irq"});
    wait_idle();
  endtask

  initial begin
    int s, s2, d, L;
    bit chain;
    model_reset();
    reset_n = 1'b0; req_in = 1'b1; done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(0, 0, "rst_status"); rd(1, 0, "rst_count"); rd(2, 0, "rst_last_busy");
    rd(3, 0, "rst_mask"); chk_irq(0, "rst_irq");
    wait_idle();

    // single block, done on the 5th busy cycle, irq then cleared
    wr(3, 1); m_irq_en = 1; wait_idle();
    toggle(s);
    wait_until(s + 5); pulse_done(); model_block(5);
    wait_until(s + 8); check_model("blk1");
    wr(0, 32'h2); m_irq_pend = 0; wait_idle();
    rd(0, 0, "blk1_status_clr"); chk_irq(0, "blk1_irq_clr"); wait_idle();

    // two toggles while busy: pend, then overrun, one extra start 2 cycles after done
    toggle(s);
    wait_until(s + 1); req_in = ~req_in;
    wait_until(s + 2); rd(0, 32'h05, "pend_status"); wait_idle();
    wait_until(s + 3); req_in = ~req_in; m_overrun = 1;
    wait_until(s + 4); rd(0, 32'h0D, "ovr_status"); wait_idle();
    wait_until(s + 6); pulse_done(); model_block(6);
    s2 = s + 8; exp_start.push_back(s2);
    wait_until(s2 + 2); pulse_done(); model_block(2);
    wait_until(s2 + 5); check_model("b2b");
    wr(0, 32'h1A); m_irq_pend = 0; m_overrun = 0; m_timeout = 0; wait_idle();
    rd(0, 0, "b2b_status_clr"); wait_idle();

    // timeout with done held low
    toggle(s);
    wait_until(s + TMO + 3); model_block(TMO + 1); check_model("tmo");
    wr(0, 32'h10); m_timeout = 0; wait_idle();
    rd(0, 32'h02, "tmo_status_clr"); wait_idle();
    wr(0, 32'h02); m_irq_pend = 0; wait_idle();
    rd(0, 0, "tmo_status_idle"); wait_idle();

    // randomized blocks, some chained through a pending request
    toggle(s);
    for (int b = 0; b < 24; b++) begin
      d = $urandom_range(1, TMO + 2);
      chain = (b < 23) && ($urandom_range(0, 2) == 0);
      if (chain) begin
        wait_until(s + 1);
        req_in = ~req_in;
      end
      if (d <= TMO) begin
        wait_until(s + d);
        pulse_done();
      end
      model_block(d);
      L = (d > TMO) ? TMO : d;
      if (chain) begin
        s = s + L + 2;
        exp_start.push_back(s);
      end else begin
        wait_until(s + L + 3);
        check_model("rnd");
        if ($urandom_range(0, 1) == 1) begin
          wr(0, 32'h1A); m_irq_pend = 0; m_timeout = 0; m_overrun = 0;
        end
        if ($urandom_range(0, 3) == 0) begin
          m_irq_en = $urandom_range(0, 1);
          wr(3, m_irq_en);
        end
        if ($urandom_range(0, 1) == 1) pulse_done();
        wait_idle();
        if (b < 23) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          toggle(s);
        end
      end
    end

    // asynchronous reset in BUSY, then a fresh request
    toggle(s);
    wait_until(s + 3);
    reset_n = 1'b0; model_reset();
    #1;
    rd(0, 0, "arst_status"); rd(1, 0, "arst_count"); rd(3, 0, "arst_mask");
    chk_irq(0, "arst_irq");
    wait_idle();
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    toggle(s);
    wait_until(s + 2);
    rd(1, 0, "arst_count_busy"); rd(0, 32'h01, "arst_status_busy"); wait_idle();
    wait_until(s + 4); pulse_done(); model_block(4);
    wait_until(s + 7); check_model("arst");

    push_op(3, 0, 0, "start_queue_empty");
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
